tariff_billing: RTL
===================

TARIFF_BILLING -- requirements
Module: tariff_billing

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD price/balance digits.
REQ-002 SHALL have parameter MODES, default 4: number of wash programs; MW = clog2(MODES).
REQ-003 SHALL have parameter TICK_DIV, default 100000000: clk cycles per 1 s tick.
REQ-004 SHALL have parameter QUOTE_SECS, default 8: payment window in ticks.
REQ-005 SHALL have parameter FINE_CAP, default 5: maximum idle-fine deductions per session.
REQ-006 SHALL have ports:
 - clk  in  1  sole clock, rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - on  in  1  machine power enable.
 - confirm  in  1  one-cycle pay pulse.
 - done  in  1  one-cycle finish pulse.
 - bal  in  4*DIGITS  BCD card balance.
 - mode  in  MW  program select.
 - price  in  MODES*4*DIGITS  packed BCD prices; slice k is mode k.
 - fine  in  4*DIGITS  BCD idle fine.
 - disp  out  4*(DIGITS+1)  display codes, MS nibble is the sign slot; 0-9 digit, 10 '-', 11 blank.
 - acc  out  4*DIGITS  BCD result magnitude.
 - neg  out  1  acc is negative.
 - state  out  3  IDLE=0, QUOTE=1, PAID=2, FINE=3, RUN=4.
 - wt_light  out  QUOTE_SECS  countdown thermometer.
 - buzz_en  out  1  prompt buzzer enable.
 - next  out  1  one-cycle handoff pulse.

Function
REQ-007 SHALL be a registered FSM; all outputs SHALL be registered, updating one cycle after the causing input.
REQ-008 SHALL go IDLE->QUOTE on the first cycle with on=1; on=0 in any state SHALL force IDLE, clear tick/countdown/fine counters and hold acc/neg.
REQ-009 In QUOTE, price SHALL be the live slice selected by mode; buzz_en=1; a tick counter SHALL wrap at TICK_DIV-1; each wrap SHALL decrement countdown (reload QUOTE_SECS on QUOTE entry) and toggle a display phase.
REQ-010 wt_light SHALL have the low countdown bits set (thermometer); all ones outside QUOTE/FINE entry reload; all zeros at countdown 0.
REQ-011 QUOTE display SHALL alternate per tick: phase 0 {11,bal}, phase 1 {10,price}; starts at phase 0.
REQ-012 confirm in QUOTE SHALL load {neg,acc} = bal - price, buzz_en=0, go PAID.
REQ-013 countdown reaching 0 without confirm SHALL load {neg,acc} = bal - fine, set fine_count=1, go FINE.
REQ-014 In FINE, each tick with fine_count<FINE_CAP SHALL subtract fine from signed acc and increment fine_count; at FINE_CAP deductions SHALL stop.
REQ-015 confirm in FINE SHALL subtract the selected price from signed acc and go PAID; confirm SHALL win over a same-cycle tick.
REQ-016 PAID and FINE SHALL display {neg?10:11, acc}.
REQ-017 done in PAID SHALL go RUN; RUN SHALL show a single '8' rotating across the DIGITS+1 positions, one position per tick, starting at the sign slot, other positions 11.
REQ-018 done in RUN SHALL pulse next for exactly one cycle and go IDLE; done in IDLE/QUOTE/FINE SHALL be ignored.
REQ-019 Arithmetic SHALL be signed-magnitude BCD; subtrahend larger than a non-negative minuend SHALL yield neg=1 with the magnitude difference; negative acc minus x SHALL grow magnitude.
REQ-020 Magnitude SHALL saturate at all-9s (10^DIGITS-1) with neg held; a zero result SHALL have neg=0.
REQ-021 IDLE SHALL display all 11 and hold buzz_en=0.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, acc=0, neg=0, disp all 11, wt_light all ones, buzz_en=0, next=0, all counters 0, regardless of clk or current state.

Verification (DIGITS=3, TICK_DIV=4, QUOTE_SECS=8, FINE_CAP=5)
REQ-023 bal=196, mode=1, price1=045, confirm at tick 2 -> state PAID, acc=151, neg=0, disp {11,1,5,1}.
REQ-024 bal=020, price=045, confirm -> acc=025, neg=1, disp {10,0,2,5}.
REQ-025 bal=196, fine=028, no confirm -> acc 168 at timeout, 056 after cap (five deductions), then stays; confirm with price 045 -> acc=011, PAID.
REQ-026 bal=000, fine=900, timeout -> acc=900, neg=1; next tick -> acc=999, neg=1 (saturated).
REQ-027 rst pulsed mid-FINE -> same-cycle state=IDLE, disp all 11, buzz_en=0; acc=0.
REQ-028 PAID, done -> RUN with '8' rotating sign slot->LS digit; second done -> next high exactly one cycle, state IDLE.

Source files
------------

// File: rtl/tariff_billing.sv
// Car-wash tariff controller: quotes the selected program price, takes payment or
// applies idle fines, runs the wash, and drives a sign-magnitude BCD display.
module tariff_billing #(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned MODES      = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned QUOTE_SECS = 8,
  parameter int unsigned FINE_CAP   = 5,
  localparam int unsigned MW        = (MODES > 1) ? $clog2(MODES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          on,
  input  logic                          confirm,
  input  logic                          done,
  input  logic [4*DIGITS-1:0]           bal,
  input  logic [MW-1:0]                 mode,
  input  logic [MODES*4*DIGITS-1:0]     price,
  input  logic [4*DIGITS-1:0]           fine,
  output logic [4*(DIGITS+1)-1:0]       disp,
  output logic [4*DIGITS-1:0]           acc,
  output logic                          neg,
  output logic [2:0]                    state,
  output logic [QUOTE_SECS-1:0]         wt_light,
  output logic                          buzz_en,
  output logic                          next
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned XW = 4 * (DIGITS + 1);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(QUOTE_SECS + 1);
  localparam int unsigned FW = $clog2(FINE_CAP + 1);
  localparam int unsigned RW = (DIGITS > 0) ? $clog2(DIGITS + 1) : 1;
  localparam logic [DW-1:0] NINES = {DIGITS{4'd9}};
  localparam logic [XW-1:0] BLANK = {(DIGITS + 1){4'd11}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUOTE = 3'd1,
    S_PAID  = 3'd2,
    S_FINE  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t          st, n_st;
  logic [TW-1:0]   tick_cnt, n_tick;
  logic [CW-1:0]   cdown, n_cd;
  logic [FW-1:0]   fine_cnt, n_fc;
  logic [RW-1:0]   rot, n_rot;
  logic            phase, n_ph;
  logic [DW-1:0]   n_acc;
  logic            n_neg, n_next, n_buzz;
  logic [XW-1:0]   n_disp;
  logic [QUOTE_SECS-1:0] n_wt;
  logic            tick;
  logic [DW-1:0]   sel_price;

  // Saturating BCD magnitude sum
  function automatic logic [DW-1:0] bcd_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          c;
    logic [4:0]    s;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      c = (s > 5'd9);
      if (c) s = s - 5'd10;
      r[4*i +: 4] = s[3:0];
    end
    return c ? NINES : r;
  endfunction

  // BCD difference, caller guarantees a >= b
  function automatic logic [DW-1:0] bcd_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          bw;
    logic [4:0]    s;
    r  = '0;
    bw = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      s  = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, bw};
      bw = s[4];
      if (bw) s = s + 5'd10;
      r[4*i +: 4] = s[3:0];
    end
    return r;
  endfunction

  // Signed-magnitude (n, m) minus non-negative x; returns {neg, magnitude}
  function automatic logic [DW:0] sub_sm(input logic n, input logic [DW-1:0] m,
                                         input logic [DW-1:0] x);
    logic [DW-1:0] r;
    logic          sign;
    if (n) begin
      r    = bcd_add(m, x);
      sign = 1'b1;
    end else if (m >= x) begin
      r    = bcd_diff(m, x);
      sign = 1'b0;
    end else begin
      r    = bcd_diff(x, m);
      sign = 1'b1;
    end
    return {sign && (r != '0), r};
  endfunction

  assign sel_price = price[DW*int'(mode) +: DW];
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign state     = st;

  // Next-state and next-output logic
  always_comb begin
    n_st   = st;
    n_tick = tick_cnt;
    n_cd   = cdown;
    n_fc   = fine_cnt;
    n_rot  = rot;
    n_ph   = phase;
    n_acc  = acc;
    n_neg  = neg;
    n_next = 1'b0;

    case (st)
      S_IDLE: begin
        n_st   = S_QUOTE;
        n_tick = '0;
        n_cd   = CW'(QUOTE_SECS);
        n_fc   = '0;
        n_ph   = 1'b0;
      end
      S_QUOTE: begin
        n_tick = tick ? '0 : tick_cnt + TW'(1);
        if (confirm) begin
          {n_neg, n_acc} = sub_sm(1'b0, bal, sel_price);
          n_st   = S_PAID;
          n_tick = '0;
        end else if (tick) begin
          n_ph = ~phase;
          n_cd = cdown - CW'(1);
          if (cdown <= CW'(1)) begin
            {n_neg, n_acc} = sub_sm(1'b0, bal, fine);
            n_fc = FW'(1);
            n_st = S_FINE;
          end
        end
      end
      S_FINE: begin
        n_tick = tick ? '0 : tick_cnt + TW'(1);
        if (confirm) begin
          {n_neg, n_acc} = sub_sm(neg, acc, sel_price);
          n_st   = S_PAID;
          n_tick = '0;
        end else if (tick && fine_cnt < FW'(FINE_CAP)) begin
          {n_neg, n_acc} = sub_sm(neg, acc, fine);
          n_fc = fine_cnt + FW'(1);
        end
      end
      S_PAID: begin
        if (done) begin
          n_st   = S_RUN;
          n_rot  = '0;
          n_tick = '0;
        end
      end
      S_RUN: begin
        n_tick = tick ? '0 : tick_cnt + TW'(1);
        if (done) begin
          n_next = 1'b1;
          n_st   = S_IDLE;
          n_tick = '0;
        end else if (tick) begin
          n_rot = (rot == RW'(DIGITS)) ? '0 : rot + RW'(1);
        end
      end
      default: n_st = S_IDLE;
    endcase

    // Power-off dominates everything but keeps the last balance
    if (!on) begin
      n_st   = S_IDLE;
      n_tick = '0;
      n_cd   = '0;
      n_fc   = '0;
      n_rot  = '0;
      n_ph   = 1'b0;
      n_acc  = acc;
      n_neg  = neg;
      n_next = 1'b0;
    end

    n_disp = BLANK;
    case (n_st)
      S_QUOTE:        n_disp = n_ph ? {4'd10, sel_price} : {4'd11, bal};
      S_PAID, S_FINE: n_disp = {(n_neg ? 4'd10 : 4'd11), n_acc};
      S_RUN:          n_disp[4*(int'(DIGITS) - int'(n_rot)) +: 4] = 4'd8;
      default:        n_disp = BLANK;
    endcase

    n_wt = '1;
    if (n_st == S_QUOTE || n_st == S_FINE) begin
      for (int i = 0; i < int'(QUOTE_SECS); i++) n_wt[i] = (CW'(i) < n_cd);
    end

    n_buzz = (n_st == S_QUOTE) || (n_st == S_FINE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      tick_cnt <= '0;
      cdown    <= '0;
      fine_cnt <= '0;
      rot      <= '0;
      phase    <= 1'b0;
      acc      <= '0;
      neg      <= 1'b0;
      disp     <= BLANK;
      wt_light <= '1;
      buzz_en  <= 1'b0;
      next     <= 1'b0;
    end else begin
      st       <= n_st;
      tick_cnt <= n_tick;
      cdown    <= n_cd;
      fine_cnt <= n_fc;
      rot      <= n_rot;
      phase    <= n_ph;
      acc      <= n_acc;
      neg      <= n_neg;
      disp     <= n_disp;
      wt_light <= n_wt;
      buzz_en  <= n_buzz;
      next     <= n_next;
    end
  end

endmodule
